// File: rtl/digit_serial_mult_if.sv
// Operand/result handshakes plus the digit link to the 3x3 product LUT.
// slave: the multiplier. master: the operand producer, consumer and LUT.
interface digit_serial_mult_if #(
  parameter int DIGITS = 2
);
  localparam int W = 3 * DIGITS;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_p;
  logic [2:0]       mul_a;
  logic [2:0]       mul_b;
  logic [5:0]       mul_p;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_p,
    output in_ready, out_valid, out_p, mul_a, mul_b
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_p,
    input  in_ready, out_valid, out_p, mul_a, mul_b
  );
endinterface

// File: rtl/digit_serial_mult.sv
// Digit-serial unsigned W x W multiplier, one 3x3 LUT product per cycle.
// Ports: clk, rst_n (async low), bus (slave): in_* operands, out_* result,
// mul_a/mul_b digits to the LUT, mul_p LUT product (same cycle).
// Option: DIGIT_SERIAL_MULT_ZERO_SKIP_EN skips MUL for a zero operand.
module digit_serial_mult #(
  parameter int DIGITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  digit_serial_mult_if.slave bus
);
  localparam int W  = 3 * DIGITS;
  localparam int PW = 2 * W;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [PW-1:0]  acc;
  logic [CW-1:0]  i;
  logic [CW-1:0]  j;
  logic           accept;
  logic           last;
  logic           zero_op;
  logic [PW-1:0]  pp;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (i == LAST) && (j == LAST);

`ifdef DIGIT_SERIAL_MULT_ZERO_SKIP_EN
  assign zero_op = (bus.in_a == '0) || (bus.in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Partial product placed at digit weight i+j, full result width.
  assign pp = PW'(bus.mul_p) << (3 * (int'(i) + int'(j)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = zero_op ? DONE : MUL;
        end
      end
      MUL: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_p     = '0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    unique case (state)
      IDLE: bus.in_ready = 1'b1;
      MUL: begin
        bus.mul_a = a_q[3*int'(i) +: 3];
        bus.mul_b = b_q[3*int'(j) +: 3];
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_p     = acc;
      end
      default: ;
    endcase
  end

  // j walks the B digits fastest; i steps once per full j sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else if (accept) begin
      a_q <= bus.in_a;
      b_q <= bus.in_b;
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else if (state == MUL) begin
      acc <= acc + pp;
      if (last) begin
        i <= '0;
        j <= '0;
      end else if (j == LAST) begin
        i <= i + 1'b1;
        j <= '0;
      end else begin
        j <= j + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_mult.sv
// Bench for digit_serial_mult: DIGITS=2 and DIGITS=3 instances,
// LUT modelled as a plain product, results checked against arithmetic.
module tb_digit_serial_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

`ifdef DIGIT_SERIAL_MULT_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  always #5 clk = ~clk;

  digit_serial_mult_if #(.DIGITS(2)) b2 ();
  digit_serial_mult_if #(.DIGITS(3)) b3 ();

  digit_serial_mult #(.DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );
  digit_serial_mult #(.DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  assign b2.mul_p = 6'(b2.mul_a) * 6'(b2.mul_b);
  assign b3.mul_p = 6'(b3.mul_a) * 6'(b3.mul_b);

  int          obs_lat;
  logic [11:0] obs_p;
  logic [63:0] obs_sig;
  int          obs_n;
  bit          obs_stable;
  logic        obs_idle_ready;
  logic        obs_idle_valid;

  // Expected LUT digit pairs: A digit outer, B digit inner, LSB first.
  function automatic logic [63:0] pair_sig(input logic [17:0] a,
                                           input logic [17:0] b,
                                           input int d);
    logic [63:0] s;
    logic [2:0]  da;
    logic [2:0]  db;
    s = '0;
    for (int x = 0; x < d; x++) begin
      for (int y = 0; y < d; y++) begin
        da = 3'(a >> (3 * x));
        db = 3'(b >> (3 * y));
        s = {s[57:0], da, db};
      end
    end
    return s;
  endfunction

  // Drives one operation on the DIGITS=2 instance and records what it saw.
  task automatic run2(input logic [5:0] a, input logic [5:0] b,
                      input int hold);
    int n;
    obs_lat = 0;
    obs_p = '1;
    obs_sig = '0;
    obs_n = 0;
    obs_stable = 1'b1;
    n = 0;
    while (b2.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    b2.in_valid = 1'b1;
    b2.in_a = a;
    b2.in_b = b;
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    b2.in_a = 6'($urandom);
    b2.in_b = 6'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (b2.out_valid === 1'b1) begin
        obs_lat = c;
        break;
      end
      obs_sig = {obs_sig[57:0], b2.mul_a, b2.mul_b};
      obs_n++;
      @(posedge clk); #1;
    end
    obs_p = b2.out_p;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (b2.out_valid !== 1'b1 || b2.out_p !== obs_p ||
          b2.in_ready !== 1'b0) obs_stable = 1'b0;
    end
    b2.out_ready = 1'b1;
    @(posedge clk); #1;
    obs_idle_ready = b2.in_ready;
    obs_idle_valid = b2.out_valid;
    b2.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0 ||
        b2.out_p !== 12'd0 || b2.mul_a !== 3'd0 || b2.mul_b !== 3'd0) begin
      failures++;
      $display("FAIL reset2 got rdy=%b vld=%b p=%0d ma=%0d mb=%0d want 1 0 0 0 0",
               b2.in_ready, b2.out_valid, b2.out_p, b2.mul_a, b2.mul_b);
    end
    checks++;
    if (b3.in_ready !== 1'b1 || b3.out_valid !== 1'b0 ||
        b3.out_p !== 18'd0) begin
      failures++;
      $display("FAIL reset3 got rdy=%b vld=%b p=%0d want 1 0 0",
               b3.in_ready, b3.out_valid, b3.out_p);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got rdy=%b vld=%b want 1 0",
               b2.in_ready, b2.out_valid);
    end
  endtask

  task automatic test_max();
    run2(6'd63, 6'd63, 0);
    checks++;
    if (obs_p !== 12'd3969) begin
      failures++;
      $display("FAIL max_p got=%0d want=3969", obs_p);
    end
    checks++;
    if (obs_lat !== 5) begin
      failures++;
      $display("FAIL max_latency got=%0d want=5", obs_lat);
    end
    checks++;
    if (obs_n !== 4 || obs_sig !== 64'hFFFFFF) begin
      failures++;
      $display("FAIL max_pairs got n=%0d sig=%h want n=4 sig=ffffff",
               obs_n, obs_sig);
    end
  endtask

  task automatic test_order();
    logic [23:0] want;
    want = {3'd5, 3'd6, 3'd5, 3'd2, 3'd1, 3'd6, 3'd1, 3'd2};
    run2(6'd13, 6'd22, 0);
    checks++;
    if (obs_p !== 12'd286) begin
      failures++;
      $display("FAIL order_p got=%0d want=286", obs_p);
    end
    checks++;
    if (obs_n !== 4 || obs_sig !== 64'(want)) begin
      failures++;
      $display("FAIL order_pairs got n=%0d sig=%h want n=4 sig=%h",
               obs_n, obs_sig, want);
    end
  endtask

  task automatic test_zero();
    int          want_lat;
    int          want_n;
    logic [63:0] want_sig;
    want_lat = ZS ? 1 : 5;
    want_n = ZS ? 0 : 4;
    want_sig = ZS ? 64'd0 : pair_sig(18'd0, 18'd45, 2);
    run2(6'd0, 6'd45, 0);
    checks++;
    if (obs_p !== 12'd0) begin
      failures++;
      $display("FAIL zero_p got=%0d want=0", obs_p);
    end
    checks++;
    if (obs_lat !== want_lat) begin
      failures++;
      $display("FAIL zero_latency got=%0d want=%0d", obs_lat, want_lat);
    end
    checks++;
    if (obs_n !== want_n || obs_sig !== want_sig) begin
      failures++;
      $display("FAIL zero_pairs got n=%0d sig=%h want n=%0d sig=%h",
               obs_n, obs_sig, want_n, want_sig);
    end
  endtask

  task automatic test_backpressure();
    run2(6'd9, 6'd7, 10);
    checks++;
    if (obs_p !== 12'd63 || obs_lat !== 5) begin
      failures++;
      $display("FAIL bp_result got p=%0d lat=%0d want p=63 lat=5",
               obs_p, obs_lat);
    end
    checks++;
    if (obs_stable !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold got stable=%b want=1", obs_stable);
    end
    checks++;
    if (obs_idle_ready !== 1'b1 || obs_idle_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0",
               obs_idle_ready, obs_idle_valid);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    b2.in_valid = 1'b1;
    b2.in_a = 6'd50;
    b2.in_b = 6'd60;
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b2.mul_a !== 3'd2 || b2.mul_b !== 3'd7) begin
      failures++;
      $display("FAIL mid_pair got (%0d,%0d) want (2,7)", b2.mul_a, b2.mul_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0 ||
        b2.out_p !== 12'd0 || b2.mul_a !== 3'd0 || b2.mul_b !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset got rdy=%b vld=%b p=%0d ma=%0d mb=%0d want 1 0 0 0 0",
               b2.in_ready, b2.out_valid, b2.out_p, b2.mul_a, b2.mul_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (b2.out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stale_valid got=%0d want=0", bad);
    end
    run2(6'd3, 6'd3, 0);
    checks++;
    if (obs_p !== 12'd9 || obs_lat !== 5) begin
      failures++;
      $display("FAIL after_reset got p=%0d lat=%0d want p=9 lat=5",
               obs_p, obs_lat);
    end
  endtask

  task automatic test_random();
    logic [5:0]  a;
    logic [5:0]  b;
    bit          skip;
    int          bad;
    bad = 0;
    for (int t = 0; t < 24; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      skip = ZS && (a == 6'd0 || b == 6'd0);
      run2(a, b, $urandom_range(0, 3));
      checks++;
      if (obs_p !== 12'(a) * 12'(b) || obs_lat !== (skip ? 1 : 5) ||
          obs_sig !== (skip ? 64'd0 : pair_sig(18'(a), 18'(b), 2))) begin
        failures++;
        bad++;
        $display("FAIL random %0d*%0d got p=%0d lat=%0d sig=%h want p=%0d",
                 a, b, obs_p, obs_lat, obs_sig, 12'(a) * 12'(b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int          lat1;
    int          lat2;
    logic [17:0] p1;
    logic [17:0] p2;
    logic [63:0] sig1;
    logic        r_idle;
    logic        v_idle;
    int          n;
    lat1 = 0;
    lat2 = 0;
    p1 = '1;
    p2 = '1;
    sig1 = '0;
    b3.in_valid = 1'b1;
    b3.in_a = 18'd511;
    b3.in_b = 18'd511;
    b3.out_ready = 1'b1;
    n = 0;
    while (b3.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    b3.in_a = 18'd1;
    for (int c = 1; c <= 40; c++) begin
      if (b3.out_valid === 1'b1) begin
        lat1 = c;
        break;
      end
      sig1 = {sig1[57:0], b3.mul_a, b3.mul_b};
      @(posedge clk); #1;
    end
    p1 = b3.out_p;
    @(posedge clk); #1;
    r_idle = b3.in_ready;
    v_idle = b3.out_valid;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      if (b3.out_valid === 1'b1) begin
        lat2 = c;
        break;
      end
      @(posedge clk); #1;
    end
    p2 = b3.out_p;
    b3.in_valid = 1'b0;
    @(posedge clk); #1;
    b3.out_ready = 1'b0;
    checks++;
    if (p1 !== 18'd261121 || lat1 !== 10) begin
      failures++;
      $display("FAIL b2b_first got p=%0d lat=%0d want p=261121 lat=10",
               p1, lat1);
    end
    checks++;
    if (sig1 !== pair_sig(18'd511, 18'd511, 3)) begin
      failures++;
      $display("FAIL b2b_pairs got sig=%h want=%h",
               sig1, pair_sig(18'd511, 18'd511, 3));
    end
    checks++;
    if (r_idle !== 1'b1 || v_idle !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got rdy=%b vld=%b want 1 0", r_idle, v_idle);
    end
    checks++;
    if (p2 !== 18'd511 || lat2 !== 10) begin
      failures++;
      $display("FAIL b2b_second got p=%0d lat=%0d want p=511 lat=10",
               p2, lat2);
    end
  endtask

  initial begin
    b2.in_valid = 1'b0;
    b2.in_a = '0;
    b2.in_b = '0;
    b2.out_ready = 1'b0;
    b3.in_valid = 1'b0;
    b3.in_a = '0;
    b3.in_b = '0;
    b3.out_ready = 1'b0;
    test_reset();
    test_max();
    test_order();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
